// File: rtl/nco_pkg.sv
// nco_pkg: shared widths, requester indices and state encoding for the NCO frequency sequencer
//   RATE_W   - width of a requested rate in kHz
//   NCO_W    - width of the NCO control word
//   REQ_HOST - requester index of the host register interface
//   REQ_HOP  - requester index of the frequency-hop table
//   state_t  - sequencer states IDLE/RESTART/WAIT/CAPTURE/DONE
package nco_pkg;
    localparam int RATE_W = 16;
    localparam int NCO_W = 32;
    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_HOP = 1'b1;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESTART = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/nco_freq_sequencer_if.sv
// nco_freq_sequencer_if: requester handshakes, converter link and phase-accumulator load bundle
//   host_req/host_rate/host_ack - host 4-phase request, rate in kHz, acknowledge
//   hop_req/hop_rate/hop_ack    - hop-table 4-phase request, rate in kHz, acknowledge
//   conv_rate/conv_restart      - rate and restart pulse to the converter
//   conv_nco                    - converter NCO word output
//   nco_word/nco_load/nco_valid - captured word, one-cycle load strobe, sticky valid
//   err/busy/last_grant         - rejection flag, sequencer busy, last requester served
//   master: requester/converter side; slave: sequencer side
interface nco_freq_sequencer_if;
    import nco_pkg::*;
    logic              host_req;
    logic [RATE_W-1:0] host_rate;
    logic              host_ack;
    logic              hop_req;
    logic [RATE_W-1:0] hop_rate;
    logic              hop_ack;
    logic [RATE_W-1:0] conv_rate;
    logic              conv_restart;
    logic [NCO_W-1:0]  conv_nco;
    logic [NCO_W-1:0]  nco_word;
    logic              nco_load;
    logic              nco_valid;
    logic              err;
    logic              busy;
    logic              last_grant;
    modport master (
        output host_req, host_rate, hop_req, hop_rate, conv_nco,
        input  host_ack, hop_ack, conv_rate, conv_restart, nco_word, nco_load, nco_valid, err, busy, last_grant
    );
    modport slave (
        input  host_req, host_rate, hop_req, hop_rate, conv_nco,
        output host_ack, hop_ack, conv_rate, conv_restart, nco_word, nco_load, nco_valid, err, busy, last_grant
    );
endinterface

// File: rtl/nco_freq_sequencer_arb.sv
// rr_arb2: two-way round-robin arbiter remembering the last requester served
//   clk, rst   - clock, asynchronous active-low reset
//   req        - request vector indexed by REQ_HOST/REQ_HOP
//   update     - commit the current grant as last_grant
//   grant      - index of the requester that wins this cycle
//   last_grant - requester served most recently (resets to hop so host wins the first tie)
module rr_arb2 import nco_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       last_grant
);
    assign grant = &req ? ~last_grant : req[REQ_HOP];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_grant <= REQ_HOP;
        else if (update) last_grant <= grant;
    end
endmodule

// File: rtl/nco_freq_sequencer.sv
// nco_freq_sequencer: arbitrates host/hop rate requests, runs the kHz-to-NCO converter, loads the NCO word
//   clk, rst - clock, asynchronous active-low reset
//   bus      - slave side of nco_freq_sequencer_if (requests, converter link, NCO load outputs)
//   CONV_CYCLES  - cycles waited after restart before sampling conv_nco
//   MAX_RATE_KHZ - largest accepted rate; zero and larger rates are rejected
//   CNT_W        - wait counter width, must hold CONV_CYCLES-1
module nco_freq_sequencer import nco_pkg::*; #(
    parameter int                CONV_CYCLES  = 34,
    parameter logic [RATE_W-1:0] MAX_RATE_KHZ = 16'd60000,
    parameter int                CNT_W        = 6
) (
    input logic                 clk,
    input logic                 rst,
    nco_freq_sequencer_if.slave bus
);
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              sel, sel_n;
    logic [RATE_W-1:0] rate, rate_n;
    logic [NCO_W-1:0]  word, word_n;
    logic              restart, restart_n, load, load_n, valid, valid_n, err, err_n;
    logic              hack, hack_n, pack, pack_n, busy;
    logic              grant, last_grant, upd;
    logic [1:0]        req;
    logic [RATE_W-1:0] g_rate;
    logic              bad;
    assign req = {bus.hop_req, bus.host_req};
    assign g_rate = grant ? bus.hop_rate : bus.host_rate;
    assign bad = g_rate == '0 || g_rate > MAX_RATE_KHZ;
    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .update     (upd),
        .grant      (grant),
        .last_grant (last_grant)
    );
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sel_n = sel;
        rate_n = rate;
        restart_n = 1'b0;
        word_n = word;
        load_n = 1'b0;
        valid_n = valid;
        err_n = err;
        hack_n = hack;
        pack_n = pack;
        upd = 1'b0;
        case (state)
            IDLE: if (|req) begin
                upd = 1'b1;
                sel_n = grant;
                if (bad) begin
                    err_n = 1'b1;
                    hack_n = grant == REQ_HOST;
                    pack_n = grant == REQ_HOP;
                    state_n = DONE;
                end else begin
                    rate_n = g_rate;
                    restart_n = 1'b1;
                    state_n = RESTART;
                end
            end
            RESTART: begin
                cnt_n = CNT_W'(CONV_CYCLES - 1);
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == '0) state_n = CAPTURE;
            end
            CAPTURE: begin
                word_n = bus.conv_nco;
                load_n = 1'b1;
                valid_n = 1'b1;
                err_n = 1'b0;
                hack_n = sel == REQ_HOST;
                pack_n = sel == REQ_HOP;
                state_n = DONE;
            end
            DONE: if (!req[sel]) begin
                hack_n = 1'b0;
                pack_n = 1'b0;
                err_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            sel <= REQ_HOST;
            rate <= '0;
            restart <= 1'b0;
            word <= '0;
            load <= 1'b0;
            valid <= 1'b0;
            err <= 1'b0;
            hack <= 1'b0;
            pack <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sel <= sel_n;
            rate <= rate_n;
            restart <= restart_n;
            word <= word_n;
            load <= load_n;
            valid <= valid_n;
            err <= err_n;
            hack <= hack_n;
            pack <= pack_n;
            busy <= state_n != IDLE;
        end
    end
    assign bus.conv_rate = rate;
    assign bus.conv_restart = restart;
    assign bus.nco_word = word;
    assign bus.nco_load = load;
    assign bus.nco_valid = valid;
    assign bus.err = err;
    assign bus.host_ack = hack;
    assign bus.hop_ack = pack;
    assign bus.busy = busy;
    assign bus.last_grant = last_grant;
endmodule

// File: tb/tb_nco_freq_sequencer.sv
// tb_nco_freq_sequencer: scoreboard bench for nco_freq_sequencer with a converter model
module tb_nco_freq_sequencer;
    import nco_pkg::*;
    typedef struct {
        logic        who;
        logic        err;
        logic [31:0] word;
        logic [15:0] rate;
        int          lat;
        logic        lg;
        int          rs;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    nco_freq_sequencer_if bus();
    nco_freq_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;
    int load_total = 0;
    logic [15:0] mrate = '0;
    int mcnt = 40;

    // Converter model: output is garbage until 32 cycles after the restart pulse.
    function automatic logic [31:0] nco_of(input logic [15:0] r);
        return r == 16'd1000 ? 32'h1179EC9C : {r, r ^ 16'hA5A5};
    endfunction
    always @(posedge clk) begin
        if (bus.conv_restart) begin
            mrate <= bus.conv_rate;
            mcnt <= 0;
        end else if (mcnt < 40) mcnt <= mcnt + 1;
    end
    assign bus.conv_nco = mcnt >= 32 ? nco_of(mrate) : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic exp_t ok(input logic who, input logic [15:0] r, input logic lg);
        exp_t e;
        e.who = who; e.err = 1'b0; e.word = nco_of(r); e.rate = r; e.lat = 36; e.lg = lg; e.rs = 1;
        return e;
    endfunction
    function automatic exp_t rej(input logic who, input logic [31:0] w, input logic [15:0] r, input logic lg);
        exp_t e;
        e.who = who; e.err = 1'b1; e.word = w; e.rate = r; e.lat = 0; e.lg = lg; e.rs = 0;
        return e;
    endfunction

    // Monitor: latency counts edges after the acceptance edge (first busy cycle = 0).
    exp_t cur;
    bit in_txn = 0, pa = 0, got = 0;
    int lat = 0, rs = 0, ld = 0;
    always @(negedge clk) begin
        if (bus.nco_load) load_total++;
        if (!rst) begin
            in_txn = 0;
            pa = 0;
        end else begin
            if (bus.busy && !in_txn) begin
                in_txn = 1; lat = 0; rs = 0; ld = 0; got = 0;
            end else if (in_txn) lat++;
            if (in_txn) begin
                rs += int'(bus.conv_restart);
                ld += int'(bus.nco_load);
            end
            if ((bus.host_ack || bus.hop_ack) && !pa) begin
                if (q.size() == 0) chk("unexpected_ack", 32'(q.size()), 32'd1);
                else begin
                    cur = q.pop_front();
                    got = 1;
                    chk("ack_who", 32'(bus.hop_ack), 32'(cur.who));
                    chk("ack_both", 32'(bus.host_ack & bus.hop_ack), 32'd0);
                    chk("err", 32'(bus.err), 32'(cur.err));
                    chk("nco_word", bus.nco_word, cur.word);
                    chk("conv_rate", 32'(bus.conv_rate), 32'(cur.rate));
                    chk("latency", 32'(lat), 32'(cur.lat));
                    chk("last_grant", 32'(bus.last_grant), 32'(cur.lg));
                    chk("nco_valid", 32'(bus.nco_valid), 32'd1);
                    chk("nco_load_at_ack", 32'(bus.nco_load), 32'(!cur.err));
                end
            end
            if (!bus.busy && in_txn) begin
                if (got) begin
                    chk("restart_pulses", 32'(rs), 32'(cur.rs));
                    chk("load_pulses", 32'(ld), 32'(cur.rs));
                end
                in_txn = 0;
            end
            pa = bus.host_ack || bus.hop_ack;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_hi(input logic who);
        int t = 0;
        while (!(who ? bus.hop_ack : bus.host_ack) && t < 300) begin
            step(1);
            t++;
        end
        chk(who ? "hop_ack_wait" : "host_ack_wait", 32'(t >= 300), 32'd0);
    endtask
    task automatic release_req(input logic who);
        chk("ack_held", 32'(who ? bus.hop_ack : bus.host_ack), 32'd1);
        if (who) bus.hop_req = 1'b0;
        else bus.host_req = 1'b0;
        step(1);
        chk("ack_release", 32'(who ? bus.hop_ack : bus.host_ack), 32'd0);
    endtask
    task automatic wait_ack(input logic who, input int hold);
        wait_hi(who);
        step(hold);
        release_req(who);
    endtask
    task automatic reset_checks();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_acks", 32'({bus.host_ack, bus.hop_ack}), 32'd0);
        chk("rst_conv_rate", 32'(bus.conv_rate), 32'd0);
        chk("rst_restart", 32'(bus.conv_restart), 32'd0);
        chk("rst_nco_word", bus.nco_word, 32'd0);
        chk("rst_load_valid_err", 32'({bus.nco_load, bus.nco_valid, bus.err}), 32'd0);
        chk("rst_last_grant", 32'(bus.last_grant), 32'd1);
    endtask

    initial begin
        int t;
        int lt;
        bus.host_req = 1'b0; bus.host_rate = '0; bus.hop_req = 1'b0; bus.hop_rate = '0;
        step(3);
        reset_checks();
        rst = 1'b1;
        step(2);
        // host-only request
        q.push_back(ok(REQ_HOST, 16'd1000, 1'b0));
        bus.host_rate = 16'd1000; bus.host_req = 1'b1;
        wait_ack(REQ_HOST, 3);
        step(2);
        // simultaneous requests straight out of reset, then a second tie
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        q.push_back(ok(REQ_HOST, 16'd500, 1'b0));
        q.push_back(ok(REQ_HOP, 16'd2000, 1'b1));
        bus.host_rate = 16'd500; bus.hop_rate = 16'd2000;
        bus.host_req = 1'b1; bus.hop_req = 1'b1;
        wait_ack(REQ_HOST, 2);
        wait_ack(REQ_HOP, 0);
        step(2);
        q.push_back(ok(REQ_HOST, 16'd3000, 1'b0));
        q.push_back(ok(REQ_HOP, 16'd4000, 1'b1));
        bus.host_rate = 16'd3000; bus.hop_rate = 16'd4000;
        bus.host_req = 1'b1; bus.hop_req = 1'b1;
        wait_ack(REQ_HOST, 0);
        wait_ack(REQ_HOP, 1);
        step(2);
        // rejections, then the largest legal rate
        q.push_back(rej(REQ_HOP, nco_of(16'd4000), 16'd4000, 1'b1));
        bus.hop_rate = 16'd0; bus.hop_req = 1'b1;
        wait_ack(REQ_HOP, 1);
        step(1);
        q.push_back(rej(REQ_HOP, nco_of(16'd4000), 16'd4000, 1'b1));
        bus.hop_rate = 16'd60001; bus.hop_req = 1'b1;
        wait_ack(REQ_HOP, 1);
        step(1);
        q.push_back(ok(REQ_HOP, 16'd60000, 1'b1));
        bus.hop_rate = 16'd60000; bus.hop_req = 1'b1;
        wait_ack(REQ_HOP, 0);
        step(2);
        // 4-phase hold with a pending hop request
        q.push_back(ok(REQ_HOST, 16'd1234, 1'b0));
        q.push_back(ok(REQ_HOP, 16'd5678, 1'b1));
        bus.host_rate = 16'd1234; bus.host_req = 1'b1;
        step(3);
        bus.hop_rate = 16'd5678; bus.hop_req = 1'b1;
        wait_hi(REQ_HOST);
        step(10);
        chk("hold_busy", 32'(bus.busy), 32'd1);
        chk("hold_hop_ack", 32'(bus.hop_ack), 32'd0);
        release_req(REQ_HOST);
        wait_ack(REQ_HOP, 0);
        step(2);
        // reset while the wait counter reads 10
        lt = load_total;
        bus.host_rate = 16'd7000; bus.host_req = 1'b1;
        t = 0;
        while (!bus.conv_restart && t < 10) begin
            step(1);
            t++;
        end
        chk("restart_wait", 32'(t >= 10), 32'd0);
        step(24);
        rst = 1'b0;
        bus.host_req = 1'b0;
        #1;
        reset_checks();
        step(2);
        rst = 1'b1;
        step(40);
        chk("no_load_after_abort", 32'(load_total), 32'(lt));
        q.push_back(ok(REQ_HOST, 16'd8000, 1'b0));
        bus.host_rate = 16'd8000; bus.host_req = 1'b1;
        wait_ack(REQ_HOST, 0);
        step(2);
        // hop request raised while a host conversion is in WAIT
        q.push_back(ok(REQ_HOST, 16'd9000, 1'b0));
        q.push_back(ok(REQ_HOP, 16'd9500, 1'b1));
        bus.host_rate = 16'd9000; bus.host_req = 1'b1;
        step(8);
        bus.hop_rate = 16'd9500; bus.hop_req = 1'b1;
        step(5);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        chk("wait_conv_rate", 32'(bus.conv_rate), 32'd9000);
        chk("wait_hop_ack", 32'(bus.hop_ack), 32'd0);
        wait_hi(REQ_HOST);
        release_req(REQ_HOST);
        t = 0;
        while (bus.busy && t < 5) begin
            step(1);
            t++;
        end
        chk("idle_gap_conv_rate", 32'(bus.conv_rate), 32'd9000);
        wait_ack(REQ_HOP, 0);
        t = 0;
        while ((q.size() != 0 || bus.busy) && t < 400) begin
            step(1);
            t++;
        end
        step(2);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
